ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port round-robin arbiter that shares one single-port synchronous RAM (1-cycle read latency, byte-strobed writes, word-addressed) between the CPU instruction-fetch port and the data load/store port. It sits between the core's fetch/LSU request interfaces and the RAM macro. It serialises accesses, registers the RAM command, and routes read data and completion back to the owning requester. It also flags out-of-range addresses without touching the RAM.

## Interface
- MEM_DEPTH, 256: RAM depth in 32-bit words. AW = $clog2(MEM_DEPTH).
- clk_i  in  1  system clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- i_req_i  in  1  fetch request; held with i_addr_i until granted.
- i_addr_i  in  32  fetch byte address; bits [1:0] ignored.
- i_gnt_o  out  1  fetch request accepted this cycle (combinational).
- i_rvalid_o  out  1  fetch response valid (1-cycle pulse).
- i_rdata_o  out  32  fetch read data, valid with i_rvalid_o.
- i_err_o  out  1  fetch address out of range, valid with i_rvalid_o.
- d_req_i  in  1  data request; held with d_we_i, d_addr_i, d_wdata_i and d_wstrb_i until granted.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  32  data byte address; bits [1:0] ignored.
- d_wdata_i  in  32  write data.
- d_wstrb_i  in  4  byte strobes; bit k enables byte lane [8k+7:8k].
- d_gnt_o  out  1  data request accepted this cycle (combinational).
- d_rvalid_o  out  1  data response pulse (reads and writes).
- d_rdata_o  out  32  data read data (for a write, the pre-write word).
- d_err_o  out  1  data address out of range, valid with d_rvalid_o.
- ram_addr_o  out  AW  word address, bit range [AW+1:2].
- ram_en_o  out  1  RAM enable.
- ram_wen_o  out  1  RAM write enable.
- ram_wdata_o  out  32  RAM write data.
- ram_wstrb_o  out  4  RAM byte strobes.
- ram_rdata_i  in  32  RAM read data; valid one cycle after ram_en_o.

## Operation
- FSM states: IDLE, CMD, RESP.
  - IDLE: may grant.
  - CMD: registered command driven to the RAM.
  - RESP: response returned to the owner; may grant.
- Grants occur only in IDLE or RESP. At most one gnt_o is high per cycle, and only when the matching req_i is high.
- Arbitration:
  - One requester active: that requester wins.
  - Both requesting: the port not granted last wins.
  - The last-grant pointer updates on every grant. Reset value = fetch, so data wins the first tie.
- On grant:
  - Latch owner, we, word address, wdata and wstrb. Fetch is always a read with wstrb = 0.
  - Latch range error = |addr[31:AW+2].
  - Next state: CMD.
- CMD:
  - ram_en_o = ~err, ram_wen_o = we & ~err, and the other ram_* outputs come from the latched command.
  - Next state: RESP.
- RESP:
  - Owner's rvalid_o = 1 and err_o = latched err.
  - rdata_o = ram_rdata_i, or 0 if err.
  - Next state: CMD if a new grant is made this cycle, else IDLE.
- Non-owner outputs: rvalid_o = 0 and err_o = 0. The non-owner rdata_o is held at its last value.
- At most one transaction is outstanding.

## Timing
- Grant in cycle N → ram_en_o high in N+1 → rvalid_o high in N+2.
- Back-to-back throughput: one access per 2 cycles; the next grant coincides with the previous RESP.
- ram_en_o is never high for two consecutive cycles.
- A write with wstrb = 0 still enables the RAM, changes no bytes, and returns a response.
- Reset values:
  - State IDLE.
  - All *_gnt_o, *_rvalid_o, *_err_o and ram_en_o/ram_wen_o are 0.
  - ram_addr_o, ram_wdata_o, ram_wstrb_o, i_rdata_o and d_rdata_o are 0.
  - Last-grant pointer = fetch.
- Reset asserted mid-transaction (in CMD or RESP):
  - Next cycle is IDLE with all outputs at reset values.
  - The aborted response is never delivered.
  - A write whose CMD cycle already occurred stays written.
- Dropping req_i before grant is legal and cancels the request. Changing request fields while req_i is held and ungranted is illegal.

## Test plan
- Single fetch, address 0x0000_0010, RAM word 4 = 0xDEAD_BEEF:
  - Required: i_gnt_o in cycle 0.
  - Required: ram_en_o=1, ram_addr_o=4 in cycle 1.
  - Required: i_rvalid_o=1, i_rdata_o=0xDEADBEEF, i_err_o=0 in cycle 2.
- Data write, address 0x8, wdata 0x1122_3344, wstrb 4'b0101, over word 0xFFFF_FFFF:
  - Required: d_rdata_o=0xFFFFFFFF with d_rvalid_o.
  - Required: a subsequent read of the same address returns 0xFF22_FF44.
- Both req held continuously from reset:
  - Required: grant order D, I, D, I…, with grants on cycles 0, 2, 4, 6.
  - Required: each rvalid appears 2 cycles after its grant, on the correct port only.
- Data read at 0x0000_0400 with MEM_DEPTH=256:
  - Required: ram_en_o stays 0.
  - Required: d_rvalid_o=1, d_err_o=1, d_rdata_o=0 in cycle 2.
- rst_i asserted in the CMD cycle of a fetch:
  - Required: no i_rvalid_o is produced.
  - Required: outputs are at reset values the next cycle.
  - Required: a fetch issued after reset completes normally.
- d_req_i asserted then dropped while an I transaction is in progress:
  - Required: d_gnt_o is never asserted and no data response occurs.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port synchronous RAM between
// the instruction-fetch port and the data load/store port. One transaction is
// in flight at a time: grant -> CMD (RAM access) -> RESP (data returned).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing outstanding; a request may be granted
//   CMD   | latched command is driven to the RAM
//   RESP  | RAM data routed to the owner; a new request may be granted
module ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_req_i,
  input  logic [31:0]   i_addr_i,
  output logic          i_gnt_o,
  output logic          i_rvalid_o,
  output logic [31:0]   i_rdata_o,
  output logic          i_err_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [31:0]   d_addr_i,
  input  logic [31:0]   d_wdata_i,
  input  logic [3:0]    d_wstrb_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_err_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_en_o,
  output logic          ram_wen_o,
  output logic [31:0]   ram_wdata_o,
  output logic [3:0]    ram_wstrb_o,
  input  logic [31:0]   ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_d_q;   // 1 = data port was granted most recently
  logic          own_d_q;    // 1 = outstanding transaction belongs to data port
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;

  logic          can_grant;
  logic          pick_d;
  logic          gnt_any;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic [31:0]   sel_addr;
  logic          unused_addr_bits;

  // Byte-offset bits never reach the word-addressed RAM.
  assign unused_addr_bits = ^{i_addr_i[1:0], d_addr_i[1:0]};

  // Round-robin arbitration and response routing.
  always_comb begin
    can_grant  = ~rst_i & ((state_q == IDLE) | (state_q == RESP));
    pick_d     = d_req_i & (~i_req_i | ~last_d_q);
    i_gnt_o    = can_grant & i_req_i & ~pick_d;
    d_gnt_o    = can_grant & pick_d;
    gnt_any    = i_gnt_o | d_gnt_o;
    sel_addr   = d_gnt_o ? d_addr_i : i_addr_i;

    resp_valid = (state_q == RESP) & ~rst_i;
    resp_data  = err_q ? 32'd0 : ram_rdata_i;
    i_rvalid_o = resp_valid & ~own_d_q;
    d_rvalid_o = resp_valid & own_d_q;
    i_err_o    = i_rvalid_o & err_q;
    d_err_o    = d_rvalid_o & err_q;
    i_rdata_o  = i_rvalid_o ? resp_data : i_rdata_q;
    d_rdata_o  = d_rvalid_o ? resp_data : d_rdata_q;

    ram_en_o    = (state_q == CMD) & ~err_q;
    ram_wen_o   = ram_en_o & we_q;
    ram_addr_o  = addr_q;
    ram_wdata_o = wdata_q;
    ram_wstrb_o = wstrb_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = CMD;
      CMD:     state_d = RESP;
      RESP:    state_d = gnt_any ? CMD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, command latch on grant, and held read data per port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      own_d_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        last_d_q <= d_gnt_o;
        own_d_q  <= d_gnt_o;
        we_q     <= d_gnt_o & d_we_i;
        err_q    <= |sel_addr[31:AW+2];
        addr_q   <= sel_addr[AW+1:2];
        wdata_q  <= d_gnt_o ? d_wdata_i : 32'd0;
        wstrb_q  <= d_gnt_o ? d_wstrb_i : 4'd0;
      end
      if (i_rvalid_o) i_rdata_q <= i_rdata_o;
      if (d_rvalid_o) d_rdata_q <= d_rdata_o;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural byte-strobed RAM.
module tb_ram_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic [3:0]  d_wstrb_i = '0;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic [7:0]  ram_addr_o;
  logic        ram_en_o, ram_wen_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_wstrb_o;
  logic [31:0] ram_rdata_i = '0;

  logic [31:0] mem [0:255];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.MEM_DEPTH(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .ram_addr_o(ram_addr_o), .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o),
    .ram_wdata_o(ram_wdata_o), .ram_wstrb_o(ram_wstrb_o),
    .ram_rdata_i(ram_rdata_i)
  );

  // RAM model: registered read of the pre-write word, byte-lane writes.
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o];
      if (ram_wen_o)
        for (int k = 0; k < 4; k++)
          if (ram_wstrb_o[k]) mem[ram_addr_o][8*k +: 8] <= ram_wdata_o[8*k +: 8];
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    i_req_i = 1'b1;
    d_req_i = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, i_err_o, d_err_o, ram_en_o, ram_wen_o} !== 8'b0) begin
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, i_err_o, d_err_o, ram_en_o, ram_wen_o});
    end else pass_cnt++;
    total_cnt++;
    if ({ram_addr_o, ram_wdata_o, ram_wstrb_o} !== 44'd0) begin
      $display("FAIL reset_ram_bus got=%h exp=0", {ram_addr_o, ram_wdata_o, ram_wstrb_o});
    end else pass_cnt++;
    total_cnt++;
    if ({i_rdata_o, d_rdata_o} !== 64'd0) begin
      $display("FAIL reset_rdata got=%h exp=0", {i_rdata_o, d_rdata_o});
    end else pass_cnt++;
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_fetch();
    mem[4] = 32'hDEAD_BEEF;
    tick();
    i_addr_i = 32'h0000_0010;
    i_req_i  = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if ({i_gnt_o, d_gnt_o, ram_en_o} !== 3'b100) begin
      $display("FAIL fetch_gnt got=%b exp=100", {i_gnt_o, d_gnt_o, ram_en_o});
    end else pass_cnt++;
    tick();
    i_req_i = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if ({ram_en_o, ram_wen_o, ram_addr_o} !== {2'b10, 8'd4}) begin
      $display("FAIL fetch_cmd got=%b_%0d exp=10_4", {ram_en_o, ram_wen_o}, ram_addr_o);
    end else pass_cnt++;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({i_rvalid_o, i_err_o, d_rvalid_o, i_rdata_o} !== {3'b100, 32'hDEAD_BEEF}) begin
      $display("FAIL fetch_resp got=%b %h exp=100 deadbeef", {i_rvalid_o, i_err_o, d_rvalid_o}, i_rdata_o);
    end else pass_cnt++;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({i_rvalid_o, i_rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin
      $display("FAIL fetch_hold got=%b %h exp=0 deadbeef", i_rvalid_o, i_rdata_o);
    end else pass_cnt++;
  endtask

  task automatic test_write();
    mem[2] = 32'hFFFF_FFFF;
    tick();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h8;
    d_wdata_i = 32'h1122_3344; d_wstrb_i = 4'b0101;
    @(negedge clk_i);
    total_cnt++;
    if ({d_gnt_o, i_gnt_o} !== 2'b10) begin
      $display("FAIL write_gnt got=%b exp=10", {d_gnt_o, i_gnt_o});
    end else pass_cnt++;
    tick();
    d_req_i = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if ({ram_en_o, ram_wen_o, ram_addr_o, ram_wstrb_o, ram_wdata_o} !== {2'b11, 8'd2, 4'b0101, 32'h1122_3344}) begin
      $display("FAIL write_cmd got=%b %0d %b %h exp=11 2 0101 11223344",
               {ram_en_o, ram_wen_o}, ram_addr_o, ram_wstrb_o, ram_wdata_o);
    end else pass_cnt++;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({d_rvalid_o, d_err_o, d_rdata_o} !== {2'b10, 32'hFFFF_FFFF}) begin
      $display("FAIL write_resp got=%b %h exp=10 ffffffff", {d_rvalid_o, d_err_o}, d_rdata_o);
    end else pass_cnt++;
    tick();
    d_req_i = 1'b1; d_we_i = 1'b0; d_wstrb_i = 4'b0000;
    @(negedge clk_i);
    tick();
    d_req_i = 1'b0;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'hFF22_FF44}) begin
      $display("FAIL write_readback got=%b %h exp=1 ff22ff44", d_rvalid_o, d_rdata_o);
    end else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    tick();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0400;
    @(negedge clk_i);
    tick();
    d_req_i = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if ({ram_en_o, ram_wen_o} !== 2'b00) begin
      $display("FAIL oor_ram_en got=%b exp=00", {ram_en_o, ram_wen_o});
    end else pass_cnt++;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({d_rvalid_o, d_err_o, i_rvalid_o, d_rdata_o} !== {3'b110, 32'd0}) begin
      $display("FAIL oor_resp got=%b %h exp=110 0", {d_rvalid_o, d_err_o, i_rvalid_o}, d_rdata_o);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt, exp_rv;
    logic       exp_en;
    rst_i = 1'b1;
    i_req_i = 1'b1; i_addr_i = 32'h10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8;
    tick();
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      // {d,i}: grants on even cycles alternate D, I; response two cycles later.
      exp_gnt = (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b10 : 2'b01);
      exp_rv  = (k < 2 || k % 2 == 1) ? 2'b00 : (((k - 2) % 4 == 0) ? 2'b10 : 2'b01);
      exp_en  = (k % 2 == 1);
      @(negedge clk_i);
      total_cnt++;
      if ({d_gnt_o, i_gnt_o, d_rvalid_o, i_rvalid_o, ram_en_o} !== {exp_gnt, exp_rv, exp_en}) begin
        $display("FAIL b2b_cycle%0d got=%b exp=%b", k,
                 {d_gnt_o, i_gnt_o, d_rvalid_o, i_rvalid_o, ram_en_o}, {exp_gnt, exp_rv, exp_en});
      end else pass_cnt++;
      tick();
    end
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    i_req_i = 1'b1; i_addr_i = 32'h10;
    @(negedge clk_i);
    tick();
    i_req_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if (i_rvalid_o !== 1'b0) begin
      $display("FAIL rstmid_cmd_rvalid got=%b exp=0", i_rvalid_o);
    end else pass_cnt++;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if ({i_rvalid_o, d_rvalid_o, ram_en_o, ram_addr_o, i_rdata_o, d_rdata_o} !== 75'd0) begin
      $display("FAIL rstmid_outputs got=%b %0d %h %h exp=000 0 0 0",
               {i_rvalid_o, d_rvalid_o, ram_en_o}, ram_addr_o, i_rdata_o, d_rdata_o);
    end else pass_cnt++;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if (i_rvalid_o !== 1'b0) begin
      $display("FAIL rstmid_no_resp got=%b exp=0", i_rvalid_o);
    end else pass_cnt++;
    tick();
    i_req_i = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if (i_gnt_o !== 1'b1) begin
      $display("FAIL rstmid_regnt got=%b exp=1", i_gnt_o);
    end else pass_cnt++;
    tick();
    i_req_i = 1'b0;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({i_rvalid_o, i_err_o, i_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      $display("FAIL rstmid_refetch got=%b %h exp=10 deadbeef", {i_rvalid_o, i_err_o}, i_rdata_o);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_cancel();
    tick();
    i_req_i = 1'b1; i_addr_i = 32'h10;
    @(negedge clk_i);
    tick();
    i_req_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8;
    @(negedge clk_i);
    total_cnt++;
    if (d_gnt_o !== 1'b0) begin
      $display("FAIL cancel_cmd_gnt got=%b exp=0", d_gnt_o);
    end else pass_cnt++;
    d_req_i = 1'b0;
    tick();
    @(negedge clk_i);
    total_cnt++;
    if ({i_rvalid_o, d_gnt_o, d_rvalid_o} !== 3'b100) begin
      $display("FAIL cancel_resp got=%b exp=100", {i_rvalid_o, d_gnt_o, d_rvalid_o});
    end else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk_i);
      total_cnt++;
      if ({d_gnt_o, d_rvalid_o, ram_en_o} !== 3'b000) begin
        $display("FAIL cancel_idle%0d got=%b exp=000", k, {d_gnt_o, d_rvalid_o, ram_en_o});
      end else pass_cnt++;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    test_reset();
    test_fetch();
    test_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_cancel();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
